// File: rtl/tinker_pkg.sv
// -----------------------------------------------------------------------------
// tinker_pkg
// Shared definitions for the Tinker core register file and the logic around it.
// - Default widths and the stack-pointer reset value.
// - The opcode enumeration.
// - writes_rd(), the one place that decides whether an opcode writes rd.
// -----------------------------------------------------------------------------
package tinker_pkg;

   localparam int              XLEN_DEFAULT     = 64;
   localparam int              NREGS_DEFAULT    = 32;
   localparam longint unsigned SP_RESET_DEFAULT = 64'd524288;

   typedef enum logic [4:0] {
      OP_AND    = 5'h00,
      OP_OR     = 5'h01,
      OP_XOR    = 5'h02,
      OP_NOT    = 5'h03,
      OP_SHFTR  = 5'h04,
      OP_SHFTRI = 5'h05,
      OP_SHFTL  = 5'h06,
      OP_SHFTLI = 5'h07,
      OP_BR     = 5'h08,
      OP_BRR    = 5'h09,
      OP_BRRL   = 5'h0a,
      OP_BRNZ   = 5'h0b,
      OP_CALL   = 5'h0c,
      OP_RETURN = 5'h0d,
      OP_BRGT   = 5'h0e,
      OP_PRIV   = 5'h0f,
      OP_MOV_MR = 5'h10,
      OP_MOV_RR = 5'h11,
      OP_MOV_RL = 5'h12,
      OP_MOV_MW = 5'h13,
      OP_ADDF   = 5'h14,
      OP_SUBF   = 5'h15,
      OP_MULF   = 5'h16,
      OP_DIVF   = 5'h17,
      OP_ADD    = 5'h18,
      OP_ADDI   = 5'h19,
      OP_SUB    = 5'h1a,
      OP_SUBI   = 5'h1b,
      OP_MUL    = 5'h1c,
      OP_DIV    = 5'h1d,
      OP_NOP    = 5'h1f
   } opcode_e;

   // Branches, calls/returns and the memory store leave the register file
   // untouched; everything else writes rd. Decode issues a scoreboard
   // increment only when this returns 1.
   function automatic logic writes_rd(opcode_e op);
      case (op)
         OP_BR, OP_BRR, OP_BRRL, OP_BRNZ, OP_CALL, OP_RETURN,
         OP_BRGT, OP_MOV_MW, OP_NOP: return 1'b0;
         default:                    return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/tinker_regfile_sb_if.sv
// -----------------------------------------------------------------------------
// tinker_regfile_sb_if
// Bundle between decode/flush/writeback logic (master) and the register file
// with scoreboard (slave).
//   rd_addr/rd_data/rd_ready : NRD packed read ports, port i at [i*W +: W]
//   sp_out                   : stack-pointer register, bypass applied
//   issue_valid/rd/ready     : decode reserves a destination register
//   kill_valid/rd            : flush squashes a reserved write
//   wb_valid/rd/data         : writeback port from MEM->WB
//   any_pending, err         : scoreboard status
// -----------------------------------------------------------------------------
interface tinker_regfile_sb_if #(
   parameter int XLEN  = 64,
   parameter int NREGS = 32,
   parameter int NRD   = 3
);
   localparam int AW = $clog2(NREGS);

   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_ready;
   logic [XLEN-1:0]     sp_out;
   logic                issue_valid;
   logic [AW-1:0]       issue_rd;
   logic                issue_ready;
   logic                kill_valid;
   logic [AW-1:0]       kill_rd;
   logic                wb_valid;
   logic [AW-1:0]       wb_rd;
   logic [XLEN-1:0]     wb_data;
   logic                any_pending;
   logic                err;

   modport master (
      output rd_addr, issue_valid, issue_rd, kill_valid, kill_rd,
             wb_valid, wb_rd, wb_data,
      input  rd_data, rd_ready, sp_out, issue_ready, any_pending, err
   );

   modport slave (
      input  rd_addr, issue_valid, issue_rd, kill_valid, kill_rd,
             wb_valid, wb_rd, wb_data,
      output rd_data, rd_ready, sp_out, issue_ready, any_pending, err
   );

endinterface

// File: rtl/tinker_sb_counter.sv
// -----------------------------------------------------------------------------
// tinker_sb_counter
// Outstanding-write counter for one architectural register.
//   clk, reset : clock, asynchronous active-high reset
//   inc_i      : an issue targets this register (ignored while saturated)
//   dec_w_i    : a writeback targets this register
//   dec_k_i    : a kill targets this register
//   cnt_o      : current count
//   sat_o      : count is at 2^PW-1, further issues must stall
//   uflow_o    : this cycle's decrements would take the count below zero
// -----------------------------------------------------------------------------
module tinker_sb_counter #(
   parameter int PW = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          inc_i,
   input  logic          dec_w_i,
   input  logic          dec_k_i,
   output logic [PW-1:0] cnt_o,
   output logic          sat_o,
   output logic          uflow_o
);

   // Two extra bits: one for the +1 headroom, one for the sign.
   localparam int NW = PW + 2;

   logic [PW-1:0]        cnt_q;
   logic [PW-1:0]        cnt_d;
   logic                 inc_eff;
   logic signed [NW-1:0] net;

   // Negative results pin at zero; the caller flags the error.
   function automatic logic [PW-1:0] clamp_cnt(logic signed [NW-1:0] v);
      if (v < 0) return '0;
      return v[PW-1:0];
   endfunction

   assign sat_o   = (cnt_q == {PW{1'b1}});
   // A saturated counter never increments, so the sum below cannot overflow.
   assign inc_eff = inc_i & ~sat_o;

   always_comb begin
      net     = signed'({2'b00, cnt_q})
              + signed'(NW'(inc_eff))
              - signed'(NW'(dec_w_i))
              - signed'(NW'(dec_k_i));
      cnt_d   = clamp_cnt(net);
      uflow_o = (net < 0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/tinker_regfile_sb.sv
// -----------------------------------------------------------------------------
// tinker_regfile_sb
// Register file with NRD combinational read ports, one writeback port,
// optional same-cycle write-to-read bypass and a per-register pending-write
// scoreboard so decode stalls only on true RAW hazards.
//   clk   : clock
//   reset : asynchronous, active-high; SP gets SP_RESET, everything else 0
//   bus   : tinker_regfile_sb_if.slave (reads, issue/kill, writeback, status)
// -----------------------------------------------------------------------------
module tinker_regfile_sb
   import tinker_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEFAULT,
   parameter int              NREGS    = NREGS_DEFAULT,
   parameter int              NRD      = 3,
   parameter int              SP_IDX   = 31,
   parameter longint unsigned SP_RESET = SP_RESET_DEFAULT,
   parameter int              PW       = 2,
   parameter int              BYPASS   = 1
) (
   input logic                 clk,
   input logic                 reset,
   tinker_regfile_sb_if.slave  bus
);

   localparam int AW  = $clog2(NREGS);
   localparam bit BYP = (BYPASS != 0);

   logic [XLEN-1:0]  regs_q [NREGS];
   logic [PW-1:0]    cnt    [NREGS];
   logic [NREGS-1:0] sat;
   logic [NREGS-1:0] uflow;
   logic [NREGS-1:0] nz;
   logic             err_q;
   logic             err_d;
   logic             sp_hit;

   // ---------------------------------------------------------------- array
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NREGS; r++)
            regs_q[r] <= (r == SP_IDX) ? XLEN'(SP_RESET) : '0;
      end else if (bus.wb_valid) begin
         regs_q[bus.wb_rd] <= bus.wb_data;
      end
   end

   // ----------------------------------------------------------- scoreboard
   for (genvar r = 0; r < NREGS; r++) begin : g_cnt
      tinker_sb_counter #(.PW(PW)) u_cnt (
         .clk     (clk),
         .reset   (reset),
         .inc_i   (bus.issue_valid && (bus.issue_rd == AW'(r))),
         .dec_w_i (bus.wb_valid    && (bus.wb_rd    == AW'(r))),
         .dec_k_i (bus.kill_valid  && (bus.kill_rd  == AW'(r))),
         .cnt_o   (cnt[r]),
         .sat_o   (sat[r]),
         .uflow_o (uflow[r])
      );
      assign nz[r] = |cnt[r];
   end

   assign bus.issue_ready = ~sat[bus.issue_rd];
   assign bus.any_pending = |nz;

   // Error is sticky: once any counter underflows it stays set until reset.
   assign err_d = err_q | (|uflow);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign bus.err = err_q;

   // ---------------------------------------------------------- read ports
   for (genvar g = 0; g < NRD; g++) begin : g_rd
      logic [AW-1:0] a;
      logic          hit;
      assign a   = bus.rd_addr[g*AW +: AW];
      assign hit = BYP && bus.wb_valid && (bus.wb_rd == a);
      assign bus.rd_data[g*XLEN +: XLEN] = hit ? bus.wb_data : regs_q[a];
      // A forwarded write resolves the hazard only if it is the last one
      // outstanding for that register.
      assign bus.rd_ready[g] = (cnt[a] == '0) || (hit && (cnt[a] == PW'(1)));
   end

   assign sp_hit     = BYP && bus.wb_valid && (bus.wb_rd == AW'(SP_IDX));
   assign bus.sp_out = sp_hit ? bus.wb_data : regs_q[SP_IDX];

endmodule

// File: tb/tb_tinker_regfile_sb.sv
module tb_tinker_regfile_sb;
   import tinker_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // shared stimulus, fed to both DUTs
   logic        s_iv = 0, s_kv = 0, s_wv = 0;
   logic [4:0]  s_ird = 0, s_krd = 0, s_wrd = 0;
   logic [63:0] s_wd = 0;
   logic [14:0] s_addr = 0;

   tinker_regfile_sb_if #(.XLEN(64), .NREGS(32), .NRD(3)) if1 ();
   tinker_regfile_sb_if #(.XLEN(64), .NREGS(32), .NRD(3)) if0 ();

   assign if1.rd_addr = s_addr;  assign if0.rd_addr = s_addr;
   assign if1.issue_valid = s_iv; assign if0.issue_valid = s_iv;
   assign if1.issue_rd = s_ird;  assign if0.issue_rd = s_ird;
   assign if1.kill_valid = s_kv; assign if0.kill_valid = s_kv;
   assign if1.kill_rd = s_krd;   assign if0.kill_rd = s_krd;
   assign if1.wb_valid = s_wv;   assign if0.wb_valid = s_wv;
   assign if1.wb_rd = s_wrd;     assign if0.wb_rd = s_wrd;
   assign if1.wb_data = s_wd;    assign if0.wb_data = s_wd;

   tinker_regfile_sb #(.BYPASS(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
   tinker_regfile_sb #(.BYPASS(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));

   // ---------------- behavioural model
   logic [63:0] mregs [32];
   int          mpend [32];
   bit          merr = 0;

   function automatic int raw_next(int r);
      int p = mpend[r];
      if (s_iv && s_ird == r && mpend[r] < 3) p = p + 1;
      if (s_wv && s_wrd == r) p = p - 1;
      if (s_kv && s_krd == r) p = p - 1;
      return p;
   endfunction

   function automatic int pend_next(int r);
      int p = raw_next(r);
      return (p < 0) ? 0 : p;
   endfunction

   function automatic bit any_under();
      for (int r = 0; r < 32; r++) if (raw_next(r) < 0) return 1'b1;
      return 1'b0;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < 32; r++) begin
            mregs[r] <= (r == 31) ? 64'd524288 : 64'd0;
            mpend[r] <= 0;
         end
         merr <= 1'b0;
      end else begin
         if (s_wv) mregs[s_wrd] <= s_wd;
         for (int r = 0; r < 32; r++) mpend[r] <= pend_next(r);
         if (any_under()) merr <= 1'b1;
      end
   end

   function automatic logic [63:0] exp_data(int a, bit byp);
      if (byp && s_wv && s_wrd == a) return s_wd;
      return mregs[a];
   endfunction

   function automatic logic exp_ready(int a, bit byp);
      return (mpend[a] == 0) || (byp && s_wv && s_wrd == a && mpend[a] == 1);
   endfunction

   function automatic logic exp_any();
      for (int r = 0; r < 32; r++) if (mpend[r] != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- per-cycle compare against the model
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         int a;
         a = int'(s_addr[i*5 +: 5]);
         chk($sformatf("b1_rd_data%0d", i), if1.rd_data[i*64 +: 64], exp_data(a, 1'b1));
         chk($sformatf("b0_rd_data%0d", i), if0.rd_data[i*64 +: 64], exp_data(a, 1'b0));
         chk($sformatf("b1_rd_ready%0d", i), 64'(if1.rd_ready[i]), 64'(exp_ready(a, 1'b1)));
         chk($sformatf("b0_rd_ready%0d", i), 64'(if0.rd_ready[i]), 64'(exp_ready(a, 1'b0)));
      end
      chk("b1_sp_out", if1.sp_out, exp_data(31, 1'b1));
      chk("b0_sp_out", if0.sp_out, exp_data(31, 1'b0));
      chk("b1_issue_ready", 64'(if1.issue_ready), 64'(mpend[s_ird] < 3));
      chk("b0_issue_ready", 64'(if0.issue_ready), 64'(mpend[s_ird] < 3));
      chk("b1_any_pending", 64'(if1.any_pending), 64'(exp_any()));
      chk("b0_any_pending", 64'(if0.any_pending), 64'(exp_any()));
      chk("b1_err", 64'(if1.err), 64'(merr));
      chk("b0_err", 64'(if0.err), 64'(merr));
   end

   // ---------------- directed stimulus with literal pins
   task automatic drive(logic iv, int ird, logic kv, int krd,
                        logic wv, int wrd, logic [63:0] wd,
                        int a0, int a1, int a2);
      s_iv = iv; s_ird = 5'(ird);
      s_kv = kv; s_krd = 5'(krd);
      s_wv = wv; s_wrd = 5'(wrd); s_wd = wd;
      s_addr = {5'(a2), 5'(a1), 5'(a0)};
   endtask

   task automatic idle(int a0, int a1, int a2);
      drive(0, 0, 0, 0, 0, 0, 64'd0, a0, a1, a2);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1 reset = 1'b1;
      idle(0, 5, 31);
      @(negedge clk);
      chk("rst_data2", if1.rd_data[128 +: 64], 64'd524288);
      chk("rst_data1", if1.rd_data[64 +: 64], 64'd0);
      chk("rst_data0", if1.rd_data[0 +: 64], 64'd0);
      chk("rst_ready", 64'(if1.rd_ready), 64'b111);
      chk("rst_any", 64'(if1.any_pending), 64'd0);
      chk("rst_issue_ready", 64'(if1.issue_ready), 64'd1);
      tick();
      reset = 1'b0;
      tick();

      // issue r5, writeback DEAD three cycles later
      drive(1, 5, 0, 0, 0, 0, 64'd0, 5, 0, 31);
      @(negedge clk); chk("iss5_ready_same", 64'(if1.rd_ready[0]), 64'd1);
      tick();
      idle(5, 0, 31);
      @(negedge clk);
      chk("iss5_b1_notready", 64'(if1.rd_ready[0]), 64'd0);
      chk("iss5_b0_notready", 64'(if0.rd_ready[0]), 64'd0);
      tick(); tick();
      drive(0, 0, 0, 0, 1, 5, 64'hDEAD, 5, 0, 31);
      @(negedge clk);
      chk("wb5_b1_data", if1.rd_data[0 +: 64], 64'hDEAD);
      chk("wb5_b1_ready", 64'(if1.rd_ready[0]), 64'd1);
      chk("wb5_b0_data", if0.rd_data[0 +: 64], 64'd0);
      chk("wb5_b0_ready", 64'(if0.rd_ready[0]), 64'd0);
      tick();
      idle(5, 0, 31);
      @(negedge clk);
      chk("wb5_b0_data_next", if0.rd_data[0 +: 64], 64'hDEAD);
      chk("wb5_b0_ready_next", 64'(if0.rd_ready[0]), 64'd1);
      tick();

      // saturate r7
      for (int k = 0; k < 3; k++) begin
         drive(1, 7, 0, 0, 0, 0, 64'd0, 7, 0, 31);
         tick();
      end
      drive(1, 7, 0, 0, 0, 0, 64'd0, 7, 0, 31);
      @(negedge clk); chk("sat7_issue_ready", 64'(if1.issue_ready), 64'd0);
      tick();
      drive(0, 7, 0, 0, 0, 0, 64'd0, 7, 0, 31);
      @(negedge clk);
      chk("sat7_still_full", 64'(if1.issue_ready), 64'd0);
      chk("sat7_any", 64'(if1.any_pending), 64'd1);
      tick();
      for (int k = 1; k <= 3; k++) begin
         drive(0, 0, 0, 0, 1, 7, 64'(k), 7, 0, 31);
         tick();
      end
      idle(7, 0, 31);
      @(negedge clk);
      chk("drain7_any", 64'(if1.any_pending), 64'd0);
      chk("drain7_ready", 64'(if0.rd_ready[0]), 64'd1);
      chk("drain7_data", if0.rd_data[0 +: 64], 64'd3);
      tick();

      // issue + writeback to r9 in one cycle with one already pending
      drive(1, 9, 0, 0, 0, 0, 64'd0, 9, 0, 31);
      tick();
      drive(1, 9, 0, 0, 1, 9, 64'd42, 9, 0, 31);
      @(negedge clk); chk("iw9_issue_ready", 64'(if1.issue_ready), 64'd1);
      tick();
      idle(9, 0, 31);
      @(negedge clk);
      chk("iw9_data", if1.rd_data[0 +: 64], 64'd42);
      chk("iw9_b1_ready", 64'(if1.rd_ready[0]), 64'd0);
      chk("iw9_b0_ready", 64'(if0.rd_ready[0]), 64'd0);
      tick();
      drive(0, 0, 0, 0, 1, 9, 64'd42, 9, 0, 31);
      tick();

      // issue / kill r3, then an extra kill
      drive(writes_rd(OP_ADD), 3, 0, 0, 0, 0, 64'd0, 3, 0, 31);
      tick();
      drive(0, 0, 1, 3, 0, 0, 64'd0, 3, 0, 31);
      tick();
      idle(3, 0, 31);
      @(negedge clk);
      chk("kill3_any", 64'(if1.any_pending), 64'd0);
      chk("kill3_err", 64'(if1.err), 64'd0);
      chk("kill3_data", if1.rd_data[0 +: 64], 64'd0);
      tick();
      drive(0, 0, 1, 3, 0, 0, 64'd0, 3, 0, 31);
      @(negedge clk); chk("kill3x_err_same", 64'(if1.err), 64'd0);
      tick();
      idle(3, 0, 31);
      @(negedge clk); chk("kill3x_err", 64'(if1.err), 64'd1);
      tick();
      drive(1, 10, 0, 0, 0, 0, 64'd0, 10, 0, 31);
      tick();
      drive(0, 0, 0, 0, 1, 10, 64'd5, 10, 0, 31);
      tick();
      idle(10, 0, 31);
      @(negedge clk);
      chk("err_sticky", 64'(if0.err), 64'd1);
      chk("wb10_data", if0.rd_data[0 +: 64], 64'd5);
      tick();

      // asynchronous reset with r4 pending twice
      drive(1, 4, 0, 0, 0, 0, 64'd0, 4, 9, 31);
      tick(); tick();
      idle(4, 9, 31);
      #2 reset = 1'b1;
      #1;
      chk("arst_any", 64'(if1.any_pending), 64'd0);
      chk("arst_sp", if1.sp_out, 64'd524288);
      chk("arst_err", 64'(if1.err), 64'd0);
      chk("arst_r9", if1.rd_data[64 +: 64], 64'd0);
      chk("arst_ready4", 64'(if1.rd_ready[0]), 64'd1);
      tick();
      reset = 1'b0;
      drive(0, 0, 0, 0, 1, 4, 64'd77, 4, 9, 31);
      @(negedge clk); chk("post_rst_err_same", 64'(if0.err), 64'd0);
      tick();
      idle(4, 9, 31);
      @(negedge clk);
      chk("post_rst_err", 64'(if1.err), 64'd1);
      chk("post_rst_data4", if1.rd_data[0 +: 64], 64'd77);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
